// File: rtl/fir_decimator.sv
// Decimator behind the FIR filter: keeps one of every DECIM accepted samples and buffers them in a show-ahead FIFO.
// Define FIR_DECIM_AVERAGE_EN to push the floor-average of each DECIM-sample block instead.
module fir_decimator #(
  parameter int DATA_W     = 16,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic signed [DATA_W-1:0]        in_sample,
  input  logic                            in_valid,
  input  logic                            flush,
  output logic signed [DATA_W-1:0]        out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);

  localparam int SH   = $clog2(DECIM);
  localparam int PH_W = (SH > 0) ? SH : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

  logic [PH_W-1:0]          r_phase;
  logic                     w_phase_last;
  logic                     w_push;
  logic signed [DATA_W-1:0] w_push_data;

  assign w_phase_last = (r_phase == PH_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (flush) begin
      r_phase <= '0;
    end else if (in_valid) begin
      r_phase <= w_phase_last ? '0 : r_phase + 1'b1;
    end
  end

`ifdef FIR_DECIM_AVERAGE_EN
  localparam int ACC_W = DATA_W + SH;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_sum;

  // Accumulator is wide enough for DECIM full-scale samples, so the sum never wraps.
  assign w_sum       = r_acc + ACC_W'(in_sample);
  assign w_push      = in_valid && w_phase_last;
  assign w_push_data = DATA_W'(w_sum >>> SH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (flush) begin
      r_acc <= '0;
    end else if (in_valid) begin
      r_acc <= w_phase_last ? '0 : w_sum;
    end
  end
`else
  assign w_push      = in_valid && (r_phase == '0);
  assign w_push_data = in_sample;
`endif

  logic signed [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [LW-1:0]            r_level;
  logic                     r_overflow;
  logic signed [DATA_W-1:0] r_hold;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_wr;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_pop   = !w_empty && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_hold     <= '0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !flush) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // When empty, present the last popped sample rather than a stale slot.
  assign out_data   = w_empty ? r_hold : r_mem[r_rd_ptr];
  assign out_valid  = !w_empty;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_fir_decimator.sv
// Self-checking bench for fir_decimator: two instances (DECIM=4/FIFO 8 and DECIM=1/FIFO 4) share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_fir_decimator;
  localparam int DW = 16;
`ifdef FIR_DECIM_AVERAGE_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic signed [DW-1:0] in_sample;
  logic signed [DW-1:0] a_data, b_data;
  logic a_valid, b_valid, a_ovf, b_ovf;
  logic [3:0] a_level;
  logic [2:0] b_level;

  always #5 clk = ~clk;

  fir_decimator #(.DATA_W(DW), .DECIM(4), .FIFO_DEPTH(8)) u_dut_a (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid), .flush(flush),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
    .fifo_level(a_level), .overflow(a_ovf));

  fir_decimator #(.DATA_W(DW), .DECIM(1), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid), .flush(flush),
    .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
    .fifo_level(b_level), .overflow(b_ovf));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: per instance, a list of queued outputs, count and running sum of accepted samples.
  int     m_dec [2] = '{4, 1};
  int     m_dep [2] = '{8, 4};
  int     m_sh  [2] = '{2, 0};
  int     mq    [2][64];
  int     mn    [2];
  int     m_cnt [2];
  longint m_sum [2];
  bit     m_ovf [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; m_cnt[k] = 0; m_sum[k] = 0; m_ovf[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit v, input int s, input bit rdy, input bit fl);
    for (int k = 0; k < 2; k++) begin
      bit push;
      int val;
      push = 1'b0;
      val  = 0;
      if (fl) begin
        mn[k] = 0; m_cnt[k] = 0; m_sum[k] = 0; m_ovf[k] = 1'b0;
      end else begin
        if (v) begin
          if (AVG) begin
            m_sum[k] += s;
            if (m_cnt[k] % m_dec[k] == m_dec[k] - 1) begin
              push = 1'b1;
              val  = int'(m_sum[k] >>> m_sh[k]);
              m_sum[k] = 0;
            end
          end else if (m_cnt[k] % m_dec[k] == 0) begin
            push = 1'b1;
            val  = s;
          end
          m_cnt[k]++;
        end
        if (mn[k] > 0 && rdy) begin
          for (int i = 0; i < 63; i++) mq[k][i] = mq[k][i+1];
          mn[k]--;
        end
        if (push) begin
          if (mn[k] < m_dep[k]) begin
            mq[k][mn[k]] = val;
            mn[k]++;
          end else begin
            m_ovf[k] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic compare_all();
    check("a_valid", int'(a_valid), int'(mn[0] > 0));
    check("a_level", int'(a_level), mn[0]);
    check("a_overflow", int'(a_ovf), int'(m_ovf[0]));
    if (mn[0] > 0) check("a_data", int'(a_data), mq[0][0]);
    check("b_valid", int'(b_valid), int'(mn[1] > 0));
    check("b_level", int'(b_level), mn[1]);
    check("b_overflow", int'(b_ovf), int'(m_ovf[1]));
    if (mn[1] > 0) check("b_data", int'(b_data), mq[1][0]);
  endtask

  int cap_a[$];
  int cap_b[$];

  task automatic cycle(input bit v, input int s, input bit rdy, input bit fl);
    in_valid  = v;
    in_sample = DW'(s);
    out_ready = rdy;
    flush     = fl;
    if (a_valid && rdy && !fl) cap_a.push_back(int'(a_data));
    if (b_valid && rdy && !fl) cap_b.push_back(int'(b_data));
    model_step(v, s, rdy, fl);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_cap(input string tag, input bit use_b, input int n,
                           input int e0, input int e1, input int e2, input int e3);
    int e[4];
    int got;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    got = use_b ? cap_b.size() : cap_a.size();
    check({tag, "_count"}, got, n);
    for (int i = 0; i < n && i < 4; i++) begin
      if (i < got) check(tag, use_b ? cap_b[i] : cap_a[i], e[i]);
      else check(tag, -99999, e[i]);
    end
    cap_a.delete();
    cap_b.delete();
  endtask

  initial begin
    logic signed [DW-1:0] r16;
    int s;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_a_valid", int'(a_valid), 0);
    check("rst_a_level", int'(a_level), 0);
    check("rst_a_overflow", int'(a_ovf), 0);
    check("rst_a_data", int'(a_data), 0);
    check("rst_b_valid", int'(b_valid), 0);
    check("rst_b_data", int'(b_data), 0);
    reset = 1'b0;

    // ramp 0..15, continuous valid and ready
    for (int i = 0; i < 16; i++) cycle(1'b1, i, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    check("ramp_overflow", int'(a_ovf), 0);
    check_cap("ramp", 1'b0, 4, AVG ? 1 : 0, AVG ? 5 : 4, AVG ? 9 : 8, AVG ? 13 : 12);

    // impulse
    cycle(1'b0, 0, 1'b1, 1'b1);
    cycle(1'b1, 10000, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    check_cap("impulse", 1'b0, 4, AVG ? 2500 : 10000, 0, 0, 0);

    // step of 800
    cycle(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 800, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    check_cap("step", 1'b0, 2, 800, 800, 0, 0);

    // negative block: floor average
    cycle(1'b0, 0, 1'b1, 1'b1);
    cycle(1'b1, -3, 1'b1, 1'b0);
    cycle(1'b1, -2, 1'b1, 1'b0);
    cycle(1'b1, -1, 1'b1, 1'b0);
    cycle(1'b1, -1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    check_cap("negative", 1'b0, 1, AVG ? -2 : -3, 0, 0, 0);

    // backpressure on the DECIM=1 instance
    cycle(1'b0, 0, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) cycle(1'b1, i, 1'b0, 1'b0);
    check("bp_level", int'(b_level), 4);
    check("bp_overflow", int'(b_ovf), 1);
    cap_a.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    check("bp_drained_valid", int'(b_valid), 0);
    check("bp_sticky_overflow", int'(b_ovf), 1);
    check_cap("bp_drain", 1'b1, 4, 1, 2, 3, 4);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("flush_overflow", int'(b_ovf), 0);

    // full FIFO: push and pop on the same edge
    for (int i = 10; i < 14; i++) cycle(1'b1, i, 1'b0, 1'b0);
    check("full_level", int'(b_level), 4);
    cycle(1'b1, 14, 1'b1, 1'b0);
    check("full_pp_level", int'(b_level), 4);
    check("full_pp_overflow", int'(b_ovf), 0);
    check("full_pp_head", int'(b_data), 11);
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b1, 1'b0);

    // asynchronous reset mid-block
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b1, 50, 1'b0, 1'b0);
    cycle(1'b1, 50, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_a_valid", int'(a_valid), 0);
    check("arst_a_level", int'(a_level), 0);
    check("arst_a_data", int'(a_data), 0);
    check("arst_b_level", int'(b_level), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cap_a.delete(); cap_b.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, 100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    check_cap("after_reset", 1'b0, 1, 100, 0, 0, 0);

    // gapped input: valid every other cycle
    cycle(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cycle(i % 2 == 0, i, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b0);
    check_cap("gapped", 1'b0, 2, AVG ? 3 : 0, AVG ? 11 : 8, 0, 0);

    // randomized traffic with bursts of backpressure and occasional flush
    for (int i = 0; i < 800; i++) begin
      r16 = DW'($urandom);
      s = int'(r16);
      cycle($urandom_range(0, 3) != 0, s,
            ((i / 40) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0),
            $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
